// File: rtl/word_bloom_filter_pkg.sv
// Shared encodings and default parameters for the word Bloom filter.
// Default hash coefficients target 5-letter, 5-bit-per-letter words.
package word_bloom_filter_pkg;

  localparam int unsigned LettersDef = 5;
  localparam int unsigned LetterWDef = 5;
  localparam int unsigned MDef       = 8;
  localparam int unsigned NumHashDef = 2;
  localparam int unsigned CntWDef    = 8;

  // Row k occupies bits [k*40 +: 40]; letter j's coefficient sits at [j*8 +: 8] within the row.
  localparam logic [NumHashDef*LettersDef*MDef-1:0] HashCoeffsDef =
      80'hba_1c_d0_f3_7f_23_d8_ae_48_24;

  typedef enum logic [1:0] {
    OpQuery  = 2'b00,
    OpInsert = 2'b01,
    OpClear  = 2'b10,
    OpRsvd   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StHash,
    StClear,
    StResp
  } state_e;

endpackage

// File: rtl/word_bloom_filter_if.sv
// Request/response handshake bundle between a requester and the Bloom filter.
interface word_bloom_filter_if #(
  parameter int unsigned WordW = 25
) ();

  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [WordW-1:0] req_word;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_hit;
  logic             rsp_err;

  modport master (
    output req_valid, req_op, req_word, rsp_ready,
    input  req_ready, rsp_valid, rsp_hit, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_word, rsp_ready,
    output req_ready, rsp_valid, rsp_hit, rsp_err
  );

endinterface

// File: rtl/word_bloom_filter_hash.sv
// Combinational multiply-accumulate of one coefficient row with a word's letters, modulo 2**M.
module word_bloom_filter_hash #(
  parameter int unsigned Letters = 5,
  parameter int unsigned LetterW = 5,
  parameter int unsigned M       = 8
) (
  input  logic [Letters*M-1:0]       coeffs_i,
  input  logic [Letters*LetterW-1:0] word_i,
  output logic [M-1:0]               hash_o
);

  logic [M-1:0] acc;
  logic [M-1:0] letter_m;

  always_comb begin
    acc      = '0;
    letter_m = '0;
    for (int j = 0; j < Letters; j++) begin
      letter_m = M'(word_i[j*LetterW +: LetterW]);
      // Everything is M bits wide, so products and sums wrap mod 2**M.
      acc = acc + coeffs_i[j*M +: M] * letter_m;
    end
  end

  assign hash_o = acc;

endmodule

// File: rtl/word_bloom_filter.sv
// Sequential Bloom filter: one hash per cycle, early-out on query miss, insert and clear ops.
module word_bloom_filter
  import word_bloom_filter_pkg::*;
#(
  parameter int unsigned                          Letters    = LettersDef,
  parameter int unsigned                          LetterW    = LetterWDef,
  parameter int unsigned                          M          = MDef,
  parameter int unsigned                          NumHash    = NumHashDef,
  parameter logic [NumHash*Letters*M-1:0]         HashCoeffs = HashCoeffsDef,
  parameter logic [(2**M)-1:0]                    InitFilter = '0,
  parameter int unsigned                          CntW       = CntWDef
) (
  input  logic                  clk,
  input  logic                  rst_n,
  word_bloom_filter_if.slave    bus,
  output logic [CntW-1:0]       insert_count_o
);

  localparam int unsigned WordW = Letters * LetterW;
  localparam int unsigned RowW  = Letters * M;
  localparam int unsigned KW    = (NumHash > 1) ? $clog2(NumHash) : 1;
  localparam int unsigned FiltN = 2 ** M;

  state_e            state_q;
  op_e               op_q;
  logic [WordW-1:0]  word_q;
  logic [KW-1:0]     k_q;
  logic [FiltN-1:0]  filter_q;
  logic              changed_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              rsp_hit_q;
  logic              rsp_err_q;
  logic [CntW-1:0]   cnt_q;

  logic [RowW-1:0]   row;
  logic [M-1:0]      idx;
  logic              bit_set;
  logic              last_k;
  logic              cnt_sat;

  always_comb begin
    row = '0;
    for (int k = 0; k < NumHash; k++) begin
      if (k_q == KW'(k)) row = HashCoeffs[k*RowW +: RowW];
    end
  end

  word_bloom_filter_hash #(
    .Letters (Letters),
    .LetterW (LetterW),
    .M       (M)
  ) u_hash (
    .coeffs_i (row),
    .word_i   (word_q),
    .hash_o   (idx)
  );

  assign bit_set = filter_q[idx];
  assign last_k  = (k_q == KW'(NumHash - 1));
  assign cnt_sat = &cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= OpQuery;
      word_q      <= '0;
      k_q         <= '0;
      filter_q    <= InitFilter;
      changed_q   <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid && req_ready_q) begin
            word_q      <= bus.req_word;
            op_q        <= op_e'(bus.req_op);
            k_q         <= '0;
            changed_q   <= 1'b0;
            req_ready_q <= 1'b0;
            unique case (op_e'(bus.req_op))
              OpQuery, OpInsert: state_q <= StHash;
              OpClear:           state_q <= StClear;
              default: begin
                state_q     <= StResp;
                rsp_valid_q <= 1'b1;
                rsp_hit_q   <= 1'b0;
                rsp_err_q   <= 1'b1;
              end
            endcase
          end
        end

        StHash: begin
          if (op_q == OpQuery) begin
            if (!bit_set || last_k) begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_hit_q   <= bit_set;
              rsp_err_q   <= 1'b0;
            end else begin
              k_q <= k_q + 1'b1;
            end
          end else begin
            // Later visits of a duplicate index see the bit this word already set.
            filter_q[idx] <= 1'b1;
            if (last_k) begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_hit_q   <= !(changed_q || !bit_set);
              rsp_err_q   <= 1'b0;
              if ((changed_q || !bit_set) && !cnt_sat) cnt_q <= cnt_q + 1'b1;
            end else begin
              k_q       <= k_q + 1'b1;
              changed_q <= changed_q || !bit_set;
            end
          end
        end

        StClear: begin
          filter_q    <= '0;
          cnt_q       <= '0;
          state_q     <= StResp;
          rsp_valid_q <= 1'b1;
          rsp_hit_q   <= 1'b0;
          rsp_err_q   <= 1'b0;
        end

        StResp: begin
          if (bus.rsp_ready) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_hit    = rsp_hit_q;
  assign bus.rsp_err    = rsp_err_q;
  assign insert_count_o = cnt_q;

endmodule

// File: tb/tb_word_bloom_filter.sv
// Directed bench for word_bloom_filter against a set-of-bits reference model.
module tb_word_bloom_filter;
  import word_bloom_filter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  word_bloom_filter_if #(.WordW(25)) bus ();
  logic [7:0] insert_count;

  word_bloom_filter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .insert_count_o (insert_count)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: the filter as a plain bit array plus a saturating counter.
  bit mdl_bits [256];
  int mdl_cnt;
  int coef [2][5] = '{'{'h24, 'h48, 'hae, 'hd8, 'h23}, '{'h7f, 'hf3, 'hd0, 'h1c, 'hba}};

  int exp_lat;
  bit exp_hit;
  bit exp_err;
  int exp_cnt;
  bit mon_active = 1'b0;
  int acc_cyc;
  int mon_n;

  task automatic chk(input string name, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
  endtask

  function automatic int mhash(input int k, input logic [24:0] w);
    int s = 0;
    for (int j = 0; j < 5; j++) s += coef[k][j] * int'(w[j*5 +: 5]);
    return s % 256;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mdl_bits[i] = 1'b0;
    mdl_cnt = 0;
  endtask

  task automatic model_op(input logic [1:0] op, input logic [24:0] w,
                          output int lat, output bit hit, output bit err);
    bit changed;
    int h;
    err = 1'b0;
    hit = 1'b0;
    case (op)
      2'b00: begin
        lat = 3;
        hit = 1'b1;
        for (int k = 0; k < 2; k++) begin
          h = mhash(k, w);
          if (!mdl_bits[h]) begin
            lat = k + 2;
            hit = 1'b0;
            break;
          end
        end
      end
      2'b01: begin
        lat = 3;
        changed = 1'b0;
        for (int k = 0; k < 2; k++) begin
          h = mhash(k, w);
          if (!mdl_bits[h]) changed = 1'b1;
          mdl_bits[h] = 1'b1;
        end
        hit = !changed;
        if (changed && mdl_cnt < 255) mdl_cnt++;
      end
      2'b10: begin
        lat = 2;
        model_reset();
      end
      default: begin
        lat = 1;
        err = 1'b1;
      end
    endcase
  endtask

  // Per-cycle response check while a transaction is outstanding.
  always @(negedge clk) begin
    if (mon_active) begin
      mon_n = cyc - acc_cyc + 1;
      chk("rsp_valid_timing", int'(bus.rsp_valid), (mon_n >= exp_lat) ? 1 : 0);
      chk("req_ready_busy", int'(bus.req_ready), 0);
      if (bus.rsp_valid) begin
        chk("rsp_hit", int'(bus.rsp_hit), int'(exp_hit));
        chk("rsp_err", int'(bus.rsp_err), int'(exp_err));
        chk("insert_count", int'(insert_count), exp_cnt);
      end
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [24:0] w, input int stall,
                        input int lit_lat, input bit lit_hit);
    int  m_lat;
    bit  m_hit;
    bit  m_err;
    bit  got;
    model_op(op, w, m_lat, m_hit, m_err);
    chk("model_latency", m_lat, lit_lat);
    chk("model_hit", int'(m_hit), int'(lit_hit));
    exp_lat = m_lat;
    exp_hit = m_hit;
    exp_err = m_err;
    exp_cnt = mdl_cnt;

    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_word  = w;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.req_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      chk("accept_timeout", 0, 1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    acc_cyc       = cyc;
    mon_active    = 1'b1;

    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk("rsp_timeout", 0, 1);
      mon_active = 1'b0;
      return;
    end
    repeat (stall) @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    mon_active    = 1'b0;
    @(negedge clk);
    chk("req_ready_after_rsp", int'(bus.req_ready), 1);
    chk("rsp_valid_after_rsp", int'(bus.rsp_valid), 0);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_word  = '0;
    bus.rsp_ready = 1'b0;
    model_reset();

    // Hand-computed hash indices pin the model.
    chk("model_h0_01", mhash(0, 25'h01), 36);
    chk("model_h1_01", mhash(1, 25'h01), 127);
    chk("model_h0_20", mhash(0, 25'h20), 72);
    chk("model_h1_20", mhash(1, 25'h20), 243);
    chk("model_h1_02", mhash(1, 25'h02), 254);
    chk("model_h0_1f", mhash(0, 25'h1f), 92);
    chk("model_h1_1f", mhash(1, 25'h1f), 97);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", int'(bus.req_ready), 1);
    chk("reset_rsp_valid", int'(bus.rsp_valid), 0);
    chk("reset_rsp_hit", int'(bus.rsp_hit), 0);
    chk("reset_rsp_err", int'(bus.rsp_err), 0);
    chk("reset_count", int'(insert_count), 0);

    run_op(OpInsert, 25'h01, 0, 3, 1'b0);
    chk("count_after_first_insert", int'(insert_count), 1);
    run_op(OpQuery,  25'h01, 0, 3, 1'b1);
    run_op(OpQuery,  25'h20, 0, 2, 1'b0);
    run_op(OpInsert, 25'h20, 0, 3, 1'b0);
    run_op(OpQuery,  25'h02, 0, 3, 1'b0);
    run_op(OpInsert, 25'h20, 0, 3, 1'b1);
    chk("count_after_reinsert", int'(insert_count), 2);
    run_op(OpInsert, 25'h1f, 0, 3, 1'b0);
    run_op(OpQuery,  25'h1f, 0, 3, 1'b1);
    run_op(OpQuery,  25'h02, 0, 3, 1'b0);
    run_op(OpRsvd,   25'h1f, 0, 1, 1'b0);
    run_op(OpQuery,  25'h01, 5, 3, 1'b1);
    run_op(OpClear,  25'h00, 0, 2, 1'b0);
    chk("count_after_clear", int'(insert_count), 0);
    run_op(OpQuery,  25'h01, 0, 2, 1'b0);
    run_op(OpInsert, 25'h01, 0, 3, 1'b0);

    // Reset while an insert is on its second hash.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = OpInsert;
    bus.req_word  = 25'h40;
    chk("ready_before_abort", int'(bus.req_ready), 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("abort_rsp_valid", int'(bus.rsp_valid), 0);
    chk("abort_count", int'(insert_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_abort_rsp_valid", int'(bus.rsp_valid), 0);
      chk("post_abort_req_ready", int'(bus.req_ready), 1);
    end
    chk("post_abort_count", int'(insert_count), 0);
    run_op(OpQuery,  25'h40, 0, 2, 1'b0);
    run_op(OpQuery,  25'h01, 0, 2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
